// File: rtl/amp_cfg_pkg.sv
// Shared definitions for the amplifier configuration sequencer:
// FSM state encoding, default bus widths, table index width and
// the sizing helper for the shared down-counter.
package amp_cfg_pkg;

    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned RETRY_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } cfg_state_e;

    // Width of the shared counter: large enough for the longest reload value.
    function automatic int unsigned timer_width(input int unsigned gap_cycles,
                                                input int unsigned timeout_cycles);
        int unsigned max_v;
        max_v = (gap_cycles > timeout_cycles) ? gap_cycles : timeout_cycles;
        if (max_v < 32'd2) begin
            max_v = 32'd2;
        end else begin
            max_v = max_v;
        end
        return $clog2(max_v + 32'd1);
    endfunction

endpackage

// File: rtl/cfg_gap_timer.sv
// Loadable down-counter with a zero flag. The sequencer reloads it on
// every state entry that needs a wait: the two-cycle FETCH settle, the
// inter-transaction GAP and, when enabled, the ISSUE response timeout.
// The counter stops at zero until the next load.
module cfg_gap_timer #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_in,
    input  logic             resetb,
    input  logic             load_in,
    input  logic [CNT_W-1:0] load_value_in,
    output logic             zero_out
);

    logic [CNT_W-1:0] count_r;

    // Reload on request, otherwise count down and hold at zero.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load_in) begin
            count_r <= load_value_in;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero_out = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/amp_config_sequencer.sv
// Amplifier configuration sequencer. On a rising edge of send_config_in it
// walks the external register table (index out, address/data back one cycle
// later) and writes each entry over the serial control bus through a
// req/ack/nack handshake, retrying nacked entries after a gap.
// Optional build macro: AMP_CFG_TIMEOUT_EN -- a missing bus response in ISSUE
// is treated as a nack after TIMEOUT_CYCLES cycles. Without it ISSUE waits
// indefinitely for the bus master.
module amp_config_sequencer
    import amp_cfg_pkg::*;
#(
    parameter int unsigned NUM_REGS       = 8,
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_in,
    input  logic              resetb,
    input  logic              send_config_in,
    output logic [IDX_W-1:0]  cfg_index_out,
    input  logic [ADDR_W-1:0] cfg_addr_in,
    input  logic [DATA_W-1:0] cfg_data_in,
    output logic              bus_req_out,
    output logic [ADDR_W-1:0] bus_addr_out,
    output logic [DATA_W-1:0] bus_data_out,
    input  logic              bus_ack_in,
    input  logic              bus_nack_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              error_out
);

    localparam int unsigned CNT_W = timer_width(GAP_CYCLES, TIMEOUT_CYCLES);

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_REGS - 32'd1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    // FETCH lasts two cycles: index settle plus one cycle of table latency.
    localparam logic [CNT_W-1:0]   FETCH_LOAD  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   GAP_LOAD    = CNT_W'(GAP_CYCLES - 32'd1);
`ifdef AMP_CFG_TIMEOUT_EN
    localparam logic [CNT_W-1:0]   ISSUE_LOAD  = CNT_W'(TIMEOUT_CYCLES - 32'd1);
`else
    localparam logic [CNT_W-1:0]   ISSUE_LOAD  = {CNT_W{1'b0}};
`endif

    cfg_state_e         state_r;
    logic               send_prev_r;
    logic [IDX_W-1:0]   idx_r;
    logic [RETRY_W-1:0] retry_r;
    logic               idx_adv_r;
    logic               abort_r;
    logic               bus_req_r;
    logic               busy_r;
    logic               done_r;
    logic               error_r;
    logic [IDX_W-1:0]   cfg_index_r;
    logic [ADDR_W-1:0]  bus_addr_r;
    logic [DATA_W-1:0]  bus_data_r;

    logic               rise_s;
    logic               timeout_s;
    logic               nack_eff_s;
    logic               resp_s;
    logic [RETRY_W-1:0] retry_inc_s;
    logic               tmr_load_s;
    logic [CNT_W-1:0]   tmr_value_s;
    logic               tmr_zero_s;

    assign rise_s = send_config_in & ~send_prev_r;

`ifdef AMP_CFG_TIMEOUT_EN
    assign timeout_s = (state_r == ST_ISSUE) && tmr_zero_s;
`else
    assign timeout_s = 1'b0;
`endif

    // Simultaneous ack+nack counts as a nack; a timeout only if no ack arrived.
    assign nack_eff_s  = bus_nack_in | (timeout_s & ~bus_ack_in);
    assign resp_s      = (state_r == ST_ISSUE) && (bus_ack_in || bus_nack_in || timeout_s);
    assign retry_inc_s = retry_r + RETRY_W'(1);

    // Edge detector for the level request from the amp state controller.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            send_prev_r <= 1'b0;
        end else begin
            send_prev_r <= send_config_in;
        end
    end

    // Counter reload on each transition into a timed state.
    always_comb begin
        tmr_load_s  = 1'b0;
        tmr_value_s = {CNT_W{1'b0}};
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (rise_s) begin
                    tmr_load_s  = 1'b1;
                    tmr_value_s = FETCH_LOAD;
                end else begin
                    tmr_load_s  = 1'b0;
                end
            end
            ST_FETCH: begin
                if (send_config_in && tmr_zero_s) begin
                    tmr_load_s  = 1'b1;
                    tmr_value_s = ISSUE_LOAD;
                end else begin
                    tmr_load_s  = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (resp_s) begin
                    tmr_load_s  = 1'b1;
                    tmr_value_s = GAP_LOAD;
                end else begin
                    tmr_load_s  = 1'b0;
                end
            end
            ST_GAP: begin
                if (send_config_in && tmr_zero_s) begin
                    tmr_load_s  = 1'b1;
                    tmr_value_s = idx_adv_r ? FETCH_LOAD : ISSUE_LOAD;
                end else begin
                    tmr_load_s  = 1'b0;
                end
            end
            default: begin
                tmr_load_s  = 1'b0;
                tmr_value_s = {CNT_W{1'b0}};
            end
        endcase
    end

    cfg_gap_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_in        (clk_in),
        .resetb        (resetb),
        .load_in       (tmr_load_s),
        .load_value_in (tmr_value_s),
        .zero_out      (tmr_zero_s)
    );

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IDX_W{1'b0}};
            retry_r     <= {RETRY_W{1'b0}};
            idx_adv_r   <= 1'b0;
            abort_r     <= 1'b0;
            bus_req_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            cfg_index_r <= {IDX_W{1'b0}};
            bus_addr_r  <= {ADDR_W{1'b0}};
            bus_data_r  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (rise_s) begin
                        state_r     <= ST_FETCH;
                        idx_r       <= {IDX_W{1'b0}};
                        retry_r     <= {RETRY_W{1'b0}};
                        idx_adv_r   <= 1'b0;
                        cfg_index_r <= {IDX_W{1'b0}};
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        error_r     <= 1'b0;
                    end else if ((state_r == ST_DONE) && !send_config_in) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (!send_config_in) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        retry_r <= {RETRY_W{1'b0}};
                    end else if (tmr_zero_s) begin
                        bus_addr_r <= cfg_addr_in;
                        bus_data_r <= cfg_data_in;
                        bus_req_r  <= 1'b1;
                        abort_r    <= 1'b0;
                        state_r    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Remember a drop of the request; the open transaction still completes.
                    if (!send_config_in) begin
                        abort_r <= 1'b1;
                    end
                    if (resp_s) begin
                        bus_req_r <= 1'b0;
                        if (abort_r || !send_config_in) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            retry_r <= {RETRY_W{1'b0}};
                            abort_r <= 1'b0;
                        end else if (nack_eff_s) begin
                            retry_r <= retry_inc_s;
                            if (retry_inc_s == RETRY_LIMIT) begin
                                state_r <= ST_ERROR;
                                error_r <= 1'b1;
                                busy_r  <= 1'b0;
                            end else begin
                                idx_adv_r <= 1'b0;
                                state_r   <= ST_GAP;
                            end
                        end else begin
                            retry_r <= {RETRY_W{1'b0}};
                            if (idx_r == LAST_IDX) begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                                busy_r  <= 1'b0;
                            end else begin
                                idx_r     <= idx_r + IDX_W'(1);
                                idx_adv_r <= 1'b1;
                                state_r   <= ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (!send_config_in) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        retry_r <= {RETRY_W{1'b0}};
                    end else if (tmr_zero_s) begin
                        if (idx_adv_r) begin
                            // New entry: refetch from the table.
                            cfg_index_r <= idx_r;
                            state_r     <= ST_FETCH;
                        end else begin
                            // Retry: re-issue the latched pair without refetch.
                            bus_req_r <= 1'b1;
                            abort_r   <= 1'b0;
                            state_r   <= ST_ISSUE;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bus_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    error_r   <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_index_out = cfg_index_r;
    assign bus_req_out   = bus_req_r;
    assign bus_addr_out  = bus_addr_r;
    assign bus_data_out  = bus_data_r;
    assign busy_out      = busy_r;
    assign done_out      = done_r;
    assign error_out     = error_r;

endmodule

// File: tb/tb_amp_config_sequencer.sv
// Directed bench for amp_config_sequencer: registered table model, a scripted
// bus responder that also logs every request, and one task per scenario.
`timescale 1ns/1ps
module tb_amp_config_sequencer;

    localparam int R_ACK  = 0;
    localparam int R_NACK = 1;
    localparam int R_BOTH = 2;
    localparam int R_NONE = 3;

    logic       clk_in = 1'b0;
    logic       resetb;
    logic       send_config_in;
    logic [3:0] cfg_index_out;
    logic [6:0] cfg_addr_in;
    logic [7:0] cfg_data_in;
    logic       bus_req_out;
    logic [6:0] bus_addr_out;
    logic [7:0] bus_data_out;
    logic       bus_ack_in;
    logic       bus_nack_in;
    logic       busy_out;
    logic       done_out;
    logic       error_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [6:0] tbl_addr [0:15];
    logic [7:0] tbl_data [0:15];

    int         resp_plan [0:255];
    int         resp_delay = 2;
    int         txn_n      = 0;
    logic [6:0] txn_addr  [0:255];
    logic [7:0] txn_data  [0:255];
    int         txn_idx   [0:255];
    int         txn_start [0:255];
    int         txn_end   [0:255];
    int         stab_err   = 0;
    bit         stray_ack  = 1'b0;

    amp_config_sequencer #(
        .NUM_REGS       (8),
        .ADDR_W         (7),
        .DATA_W         (8),
        .MAX_RETRY      (3),
        .GAP_CYCLES     (16),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk_in         (clk_in),
        .resetb         (resetb),
        .send_config_in (send_config_in),
        .cfg_index_out  (cfg_index_out),
        .cfg_addr_in    (cfg_addr_in),
        .cfg_data_in    (cfg_data_in),
        .bus_req_out    (bus_req_out),
        .bus_addr_out   (bus_addr_out),
        .bus_data_out   (bus_data_out),
        .bus_ack_in     (bus_ack_in),
        .bus_nack_in    (bus_nack_in),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .error_out      (error_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // External table: one cycle of read latency.
    always @(posedge clk_in) begin
        cfg_addr_in <= tbl_addr[cfg_index_out];
        cfg_data_in <= tbl_data[cfg_index_out];
    end

    // Bus master model: logs requests, answers after resp_delay per resp_plan.
    initial begin : bus_model
        bit         req_prev;
        bit         resp_sent;
        int         wait_cnt;
        int         mode;
        logic [6:0] hold_addr;
        logic [7:0] hold_data;
        req_prev = 1'b0; resp_sent = 1'b0; wait_cnt = 0;
        hold_addr = 7'd0; hold_data = 8'd0;
        bus_ack_in = 1'b0; bus_nack_in = 1'b0;
        forever begin
            @(negedge clk_in);
            bus_ack_in = 1'b0; bus_nack_in = 1'b0;
            if (bus_req_out && !req_prev) begin
                if (txn_n < 255) begin
                    txn_addr[txn_n]  = bus_addr_out;
                    txn_data[txn_n]  = bus_data_out;
                    txn_idx[txn_n]   = int'(cfg_index_out);
                    txn_start[txn_n] = cyc;
                    txn_n++;
                end
                wait_cnt = 0; resp_sent = 1'b0;
            end else if (bus_req_out) begin
                if (bus_addr_out !== hold_addr || bus_data_out !== hold_data) stab_err++;
            end else if (req_prev && txn_n > 0) begin
                txn_end[txn_n-1] = cyc;
            end
            if (bus_req_out && !resp_sent) begin
                if (wait_cnt >= resp_delay) begin
                    mode = resp_plan[txn_n-1];
                    case (mode)
                        R_ACK:   bus_ack_in = 1'b1;
                        R_NACK:  bus_nack_in = 1'b1;
                        R_BOTH:  begin bus_ack_in = 1'b1; bus_nack_in = 1'b1; end
                        default: ;
                    endcase
                    resp_sent = (mode != R_NONE);
                end else begin
                    wait_cnt++;
                end
            end
            if (stray_ack) begin
                bus_ack_in = 1'b1;
                stray_ack  = 1'b0;
            end
            req_prev  = bus_req_out;
            hold_addr = bus_addr_out;
            hold_data = bus_data_out;
        end
    end

    task automatic raise_send(output int t0);
        send_config_in = 1'b0;
        @(negedge clk_in);
        send_config_in = 1'b1;
        t0 = cyc;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_in);
            if (!busy_out && !bus_req_out) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic wait_txn(input int target, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_in);
            if (txn_n >= target) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        send_config_in = 1'b0;
        repeat (3) @(negedge clk_in);
        n_checks++;
        if ({bus_req_out, busy_out, done_out, error_out} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {bus_req_out, busy_out, done_out, error_out});
        end
        n_checks++;
        if ({cfg_index_out, bus_addr_out, bus_data_out} !== 19'd0) begin
            n_fail++; $display("FAIL reset_busses: got idx %0d addr %0h data %0h expected 0", cfg_index_out, bus_addr_out, bus_data_out);
        end
        resetb = 1'b1;
        @(negedge clk_in);
        stray_ack = 1'b1;
        repeat (4) @(negedge clk_in);
        n_checks++;
        if ({bus_req_out, busy_out, done_out, error_out} !== 4'b0000) begin
            n_fail++; $display("FAIL stray_ack_idle: got %b expected 0000", {bus_req_out, busy_out, done_out, error_out});
        end
    endtask

    task automatic test_full_sequence();
        int base, t0; bit ok;
        base = txn_n;
        raise_send(t0);
        @(negedge clk_in);
        n_checks++;
        if (busy_out !== 1'b1) begin n_fail++; $display("FAIL seq_busy: got %b expected 1", busy_out); end
        wait_idle(800, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL seq_timeout: got busy expected idle within 800 cycles"); end
        n_checks++;
        if (txn_n - base != 8) begin n_fail++; $display("FAIL seq_count: got %0d expected 8", txn_n - base); end
        n_checks++;
        if (txn_start[base] - t0 != 3) begin n_fail++; $display("FAIL seq_latency: got %0d expected 3", txn_start[base] - t0); end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (txn_addr[base+k] !== tbl_addr[k] || txn_data[base+k] !== tbl_data[k] || txn_idx[base+k] != k) begin
                n_fail++;
                $display("FAIL seq_entry%0d: got idx %0d addr %0h data %0h expected idx %0d addr %0h data %0h",
                         k, txn_idx[base+k], txn_addr[base+k], txn_data[base+k], k, tbl_addr[k], tbl_data[k]);
            end
        end
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (txn_start[base+k+1] - txn_end[base+k] != 18) begin
                n_fail++; $display("FAIL seq_gap%0d: got %0d expected 18", k, txn_start[base+k+1] - txn_end[base+k]);
            end
        end
        n_checks++;
        if ({done_out, error_out, busy_out} !== 3'b100) begin
            n_fail++; $display("FAIL seq_done: got done/err/busy %b expected 100", {done_out, error_out, busy_out});
        end
        n_checks++;
        if (stab_err != 0) begin n_fail++; $display("FAIL seq_stable: got %0d changes expected 0", stab_err); end
        send_config_in = 1'b0;
        @(negedge clk_in);
        n_checks++;
        if (done_out !== 1'b0) begin n_fail++; $display("FAIL done_clear_on_low: got %b expected 0", done_out); end
    endtask

    task automatic test_retry();
        int base, t0; bit ok;
        base = txn_n;
        resp_plan[base+3] = R_NACK;
        resp_plan[base+4] = R_NACK;
        raise_send(t0);
        wait_idle(900, ok);
        n_checks++;
        if (!ok || txn_n - base != 10) begin
            n_fail++; $display("FAIL retry_count: got %0d txns (idle %0d) expected 10", txn_n - base, ok);
        end
        for (int k = 3; k < 6; k++) begin
            n_checks++;
            if (txn_idx[base+k] != 3 || txn_addr[base+k] !== tbl_addr[3] || txn_data[base+k] !== tbl_data[3]) begin
                n_fail++; $display("FAIL retry_entry%0d: got idx %0d addr %0h expected idx 3 addr %0h", k, txn_idx[base+k], txn_addr[base+k], tbl_addr[3]);
            end
        end
        n_checks++;
        if (txn_start[base+4] - txn_end[base+3] != 16) begin
            n_fail++; $display("FAIL retry_gap: got %0d expected 16", txn_start[base+4] - txn_end[base+3]);
        end
        n_checks++;
        if (txn_idx[base+6] != 4 || txn_addr[base+6] !== tbl_addr[4]) begin
            n_fail++; $display("FAIL retry_next: got idx %0d expected 4", txn_idx[base+6]);
        end
        n_checks++;
        if ({done_out, error_out} !== 2'b10) begin n_fail++; $display("FAIL retry_done: got %b expected 10", {done_out, error_out}); end
        send_config_in = 1'b0;
    endtask

    task automatic test_error();
        int base, base2, t0; bit ok;
        base = txn_n;
        resp_plan[base+5] = R_NACK;
        resp_plan[base+6] = R_NACK;
        resp_plan[base+7] = R_NACK;
        raise_send(t0);
        wait_idle(900, ok);
        n_checks++;
        if ({ok, error_out, done_out} !== 3'b110) begin
            n_fail++; $display("FAIL err_flags: got idle/err/done %b expected 110", {ok, error_out, done_out});
        end
        n_checks++;
        if (cfg_index_out !== 4'd5) begin n_fail++; $display("FAIL err_index: got %0d expected 5", cfg_index_out); end
        n_checks++;
        if (txn_n - base != 8) begin n_fail++; $display("FAIL err_count: got %0d expected 8", txn_n - base); end
        send_config_in = 1'b0;
        repeat (40) @(negedge clk_in);
        n_checks++;
        if (txn_n - base != 8 || error_out !== 1'b1 || bus_req_out !== 1'b0) begin
            n_fail++; $display("FAIL err_hold: got txns %0d err %b req %b expected 8 1 0", txn_n - base, error_out, bus_req_out);
        end
        base2 = txn_n;
        raise_send(t0);
        @(negedge clk_in);
        n_checks++;
        if ({error_out, busy_out, cfg_index_out} !== {1'b0, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL err_restart: got err %b busy %b idx %0d expected 0 1 0", error_out, busy_out, cfg_index_out);
        end
        wait_idle(800, ok);
        n_checks++;
        if (!ok || done_out !== 1'b1 || txn_n - base2 != 8 || txn_idx[base2] != 0 || txn_addr[base2] !== tbl_addr[0]) begin
            n_fail++; $display("FAIL err_rerun: got done %b txns %0d first idx %0d expected 1 8 0", done_out, txn_n - base2, txn_idx[base2]);
        end
        send_config_in = 1'b0;
    endtask

    task automatic test_abort_issue();
        int base, t0; bit ok;
        base = txn_n;
        resp_plan[base+2] = R_NONE;
        raise_send(t0);
        wait_txn(base + 3, 200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL abort_reach: got %0d txns expected 3", txn_n - base); end
        send_config_in = 1'b0;
        repeat (10) @(negedge clk_in);
        n_checks++;
        if ({bus_req_out, busy_out} !== 2'b11) begin
            n_fail++; $display("FAIL abort_hold_req: got req/busy %b expected 11", {bus_req_out, busy_out});
        end
        resp_plan[base+2] = R_ACK;
        wait_idle(20, ok);
        n_checks++;
        if ({ok, done_out, error_out} !== 3'b100) begin
            n_fail++; $display("FAIL abort_idle: got idle/done/err %b expected 100", {ok, done_out, error_out});
        end
        repeat (40) @(negedge clk_in);
        n_checks++;
        if (txn_n - base != 3 || busy_out !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_next: got txns %0d busy %b expected 3 0", txn_n - base, busy_out);
        end
    endtask

    task automatic test_ack_nack_same();
        int base, t0; bit ok;
        base = txn_n;
        resp_plan[base] = R_BOTH;
        raise_send(t0);
        wait_idle(900, ok);
        n_checks++;
        if (!ok || txn_n - base != 9) begin n_fail++; $display("FAIL both_count: got %0d expected 9", txn_n - base); end
        n_checks++;
        if (txn_idx[base+1] != 0 || txn_addr[base+1] !== tbl_addr[0] || txn_data[base+1] !== tbl_data[0]) begin
            n_fail++; $display("FAIL both_reissue: got idx %0d addr %0h expected 0 %0h", txn_idx[base+1], txn_addr[base+1], tbl_addr[0]);
        end
        n_checks++;
        if (txn_start[base+1] - txn_end[base] != 16) begin
            n_fail++; $display("FAIL both_gap: got %0d expected 16", txn_start[base+1] - txn_end[base]);
        end
        n_checks++;
        if (done_out !== 1'b1 || txn_idx[base+2] != 1) begin
            n_fail++; $display("FAIL both_done: got done %b next idx %0d expected 1 1", done_out, txn_idx[base+2]);
        end
        send_config_in = 1'b0;
    endtask

    task automatic test_timeout();
        int base, t0; bit ok;
        base = txn_n;
`ifdef AMP_CFG_TIMEOUT_EN
        resp_plan[base]   = R_NONE;
        resp_plan[base+1] = R_NONE;
        resp_plan[base+2] = R_NONE;
        raise_send(t0);
        wait_idle(600, ok);
        n_checks++;
        if (!ok || txn_n - base != 3 || error_out !== 1'b1) begin
            n_fail++; $display("FAIL tmo_error: got txns %0d err %b expected 3 1", txn_n - base, error_out);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (txn_end[base+k] - txn_start[base+k] != 64) begin
                n_fail++; $display("FAIL tmo_len%0d: got %0d expected 64", k, txn_end[base+k] - txn_start[base+k]);
            end
        end
        send_config_in = 1'b0;
`else
        resp_plan[base] = R_NONE;
        raise_send(t0);
        repeat (300) @(negedge clk_in);
        n_checks++;
        if ({bus_req_out, busy_out, error_out} !== 3'b110 || txn_n - base != 1) begin
            n_fail++; $display("FAIL no_tmo_wait: got req/busy/err %b txns %0d expected 110 1", {bus_req_out, busy_out, error_out}, txn_n - base);
        end
        resetb = 1'b0;
        #1;
        n_checks++;
        if ({bus_req_out, busy_out} !== 2'b00) begin
            n_fail++; $display("FAIL no_tmo_reset: got req/busy %b expected 00", {bus_req_out, busy_out});
        end
        send_config_in = 1'b0;
        @(negedge clk_in);
        resetb = 1'b1;
`endif
    endtask

    task automatic test_reset_mid();
        int base, t0; bit ok;
        base = txn_n;
        resp_plan[base] = R_NONE;
        raise_send(t0);
        wait_txn(base + 1, 100, ok);
        n_checks++;
        if (!ok || bus_req_out !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reach: got req %b expected 1", bus_req_out); end
        resetb = 1'b0;
        #1;
        n_checks++;
        if ({bus_req_out, busy_out, cfg_index_out, bus_addr_out} !== 13'd0) begin
            n_fail++; $display("FAIL rst_mid_clear: got req %b busy %b idx %0d addr %0h expected 0", bus_req_out, busy_out, cfg_index_out, bus_addr_out);
        end
        send_config_in = 1'b0;
        @(negedge clk_in);
        resetb = 1'b1;
        @(negedge clk_in);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl_addr[i] = 7'(32 + i * 5);
            tbl_data[i] = 8'(8'hC3 ^ 8'(i * 29));
        end
        resetb = 1'b0;
        send_config_in = 1'b0;
        test_reset();
        test_full_sequence();
        test_retry();
        test_error();
        test_abort_issue();
        test_ack_nack_same();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/amp_config_sequencer.md
Name: amp_config_sequencer

Overview:
Writes the amplifier's configuration register table over a serial control bus, one register per transaction, when the amp state controller requests it via send_config.
- Fetches each address/data pair from an external config table.
- Issues each pair to the bus master through a req/ack/nack handshake, retrying on nack.
- Reports busy/done/error back to the amp interface.

Parameters:
NUM_REGS, 8, number of table entries written per sequence (1..16)
ADDR_W, 7, register address width
DATA_W, 8, register data width
MAX_RETRY, 3, nacks tolerated per entry before error (1..7)
GAP_CYCLES, 16, idle clk_in cycles between transactions (>=1)
TIMEOUT_CYCLES, 1024, response timeout (used only with the optional feature)

Ports:
clk_in  in  1  system clock
resetb  in  1  asynchronous active-low reset
send_config_in  in  1  level request; a rising edge starts a sequence
cfg_index_out  out  4  table index; entry is valid 1 cycle after index changes
cfg_addr_in  in  ADDR_W  table address for cfg_index_out
cfg_data_in  in  DATA_W  table data for cfg_index_out
bus_req_out  out  1  transaction request, held high until response
bus_addr_out  out  ADDR_W  latched address, stable while bus_req_out is high
bus_data_out  out  DATA_W  latched data, stable while bus_req_out is high
bus_ack_in  in  1  1-cycle pulse, write accepted
bus_nack_in  in  1  1-cycle pulse, write rejected
busy_out  out  1  high in any state other than IDLE, DONE or ERROR
done_out  out  1  all entries acknowledged
error_out  out  1  entry exceeded retry limit (or timed out)

Behaviour:
- Reset (async, resetb low): state IDLE. All outputs 0, including cfg_index_out and bus_addr/data_out. Internal idx, retry and counter cleared. send_config edge-detect register cleared.
- Start: send_config_in is sampled into a 1-flop edge detector; rise = in & ~prev.
  - Rise in IDLE, DONE or ERROR -> FETCH with idx=0, retry=0; done_out and error_out clear.
  - Rise in any other state is ignored.
- States:
  - IDLE: wait for rise.
  - FETCH: cfg_index_out=idx. Stay exactly 2 cycles (index settle + table latency). Latch cfg_addr_in/cfg_data_in into bus_addr/data_out, then -> ISSUE.
  - ISSUE: bus_req_out=1. Leave on the first cycle with a response; bus_req_out drops on the next cycle.
    - ack -> retry=0; if idx==NUM_REGS-1 -> DONE, else idx++ and -> GAP.
    - nack -> retry++; if new retry==MAX_RETRY -> ERROR, else -> GAP; the same entry is re-issued without refetch.
  - GAP: counter runs GAP_CYCLES cycles. Then -> FETCH if idx advanced, else -> ISSUE.
  - DONE: done_out=1, held until the next rise or until send_config_in is low, whichever comes first; then -> IDLE.
  - ERROR: error_out=1, held until the next rise. cfg_index_out holds the failing idx.
- Abort: send_config_in low while in FETCH or GAP -> IDLE next cycle. Low during ISSUE: the transaction completes (ack or nack), then -> IDLE. bus_req_out never drops without a response.
- Simultaneous ack and nack: treated as nack.
- Response outside ISSUE: ignored.
- Latency, NUM_REGS=8, zero-wait bus: rise to first bus_req_out = 3 cycles (edge + 2 FETCH).
- Reset asserted mid-transaction: bus_req_out drops immediately. The bus master is reset by the same resetb.

Optional Feature:
AMP_CFG_TIMEOUT_EN:
- Defined: in ISSUE, a counter runs from entry. If TIMEOUT_CYCLES elapse with no response, this is treated exactly as a nack (retry++ / ERROR). An abort during a timeout-pending ISSUE exits at timeout.
- Undefined: no timeout logic, TIMEOUT_CYCLES unused, ISSUE waits indefinitely.

Decomposition:
- Package amp_cfg_pkg:
  - state encodings (IDLE, FETCH, ISSUE, GAP, DONE, ERROR; 3-bit)
  - default widths ADDR_W/DATA_W
  - index width constant (4)
- Sub-module cfg_gap_timer: a loadable down-counter with a zero flag. It is shared for the FETCH wait, the GAP and, with the macro, the ISSUE timeout (one instance, reloaded per state).

Test Plan:
- Reset then rise on send_config_in, NUM_REGS=8, bus acks 2 cycles after each req -> 8 transactions with addr/data matching table entries 0..7 in order, each separated by >=16 idle cycles; then done_out=1, busy_out=0.
- Entry 3 nacked twice then acked (MAX_RETRY=3) -> entry 3 issued 3 times without cfg_index_out change; sequence completes with done_out=1.
- Entry 5 nacked 3 times -> error_out=1, cfg_index_out=5, no further bus_req_out; a new rise restarts from idx 0 with error_out cleared.
- send_config_in drops while ISSUE waits on entry 2; ack arrives 10 cycles later -> bus_req_out held until ack, then IDLE, all flags 0, no entry 3 request.
- ack and nack in the same cycle on entry 0 -> counted as a nack, entry 0 reissued after the gap.
- With AMP_CFG_TIMEOUT_EN, TIMEOUT_CYCLES=64, bus never responds -> 3 requests each lasting 64 cycles, then error_out=1. Without the macro -> bus_req_out stays high indefinitely.
